// File: rtl/vit_pkg.sv
// rtl/vit_pkg.sv - shared trellis constants, types and predecessor helpers for the Viterbi ACS
package vit_pkg;

    localparam int NUM_STATES = 8;
    localparam int BM_W       = 2;

    typedef logic [BM_W-1:0] bm_t;

    // Initial metric vector layout: a set bit marks a state that starts at 0,
    // every other state starts at INIT_METRIC (only state 0 is known at frame start).
    localparam logic [NUM_STATES-1:0] INIT_ZERO_MASK = 8'b0000_0001;

    // Rate 1/2, K=4 shift-register trellis: state s is entered from 2*(s mod 4) and 2*(s mod 4)+1.
    function automatic int pred0(input int s);
        return 2 * (s % 4);
    endfunction

    function automatic int pred1(input int s);
        return 2 * (s % 4) + 1;
    endfunction

endpackage

// File: rtl/acs_cell.sv
// rtl/acs_cell.sv - combinational add-compare-select for one trellis state
module acs_cell
    import vit_pkg::*;
#(
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] old0,
    input  logic [PM_W-1:0] old1,
    input  bm_t             bm0,
    input  bm_t             bm1,
    output logic [PM_W-1:0] new_pm,
    output logic            decision
);

    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] c0;
    logic [PM_W-1:0] c1;

    // Widen by one bit so the carry is visible, clamp to all-ones, then keep the strictly smaller candidate.
    always_comb begin
        sum0     = {1'b0, old0} + {{(PM_W + 1 - BM_W){1'b0}}, bm0};
        sum1     = {1'b0, old1} + {{(PM_W + 1 - BM_W){1'b0}}, bm1};
        c0       = sum0[PM_W] ? {PM_W{1'b1}} : sum0[PM_W-1:0];
        c1       = sum1[PM_W] ? {PM_W{1'b1}} : sum1[PM_W-1:0];
        decision = (c1 < c0);
        new_pm   = decision ? c1 : c0;
    end

endmodule

// File: rtl/path_metric_unit.sv
// rtl/path_metric_unit.sv - 8-state ACS stage with path metric registers, normalization and best-state search
module path_metric_unit
    import vit_pkg::*;
#(
    parameter int PM_W        = 8,
    parameter int INIT_METRIC = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            in_valid,
    input  logic [15:0]     bm0,
    input  logic [15:0]     bm1,
    output logic            out_valid,
    output logic [7:0]      decisions,
    output logic [2:0]      best_state,
    output logic [PM_W-1:0] best_metric
);

    localparam logic [PM_W-1:0] INIT_PM = PM_W'(INIT_METRIC);

    logic [PM_W-1:0]       pm     [NUM_STATES];
    logic [PM_W-1:0]       old_pm [NUM_STATES];
    logic [PM_W-1:0]       sel_pm [NUM_STATES];
    logic [PM_W-1:0]       new_pm [NUM_STATES];
    logic [NUM_STATES-1:0] dec;
    logic [NUM_STATES-1:0] msb;
    logic                  norm;
    logic [2:0]            min_state;
    logic [PM_W-1:0]       min_metric;

    // A frame-start step ignores the registered metrics and restarts from the known-state vector.
    always_comb begin
        for (int s = 0; s < NUM_STATES; s++) begin
            if (frame_start && in_valid)
                old_pm[s] = INIT_ZERO_MASK[s] ? '0 : INIT_PM;
            else
                old_pm[s] = pm[s];
        end
    end

    for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
        acs_cell #(
            .PM_W (PM_W)
        ) u_acs (
            .old0     (old_pm[pred0(s)]),
            .old1     (old_pm[pred1(s)]),
            .bm0      (bm0[2*s +: 2]),
            .bm1      (bm1[2*s +: 2]),
            .new_pm   (sel_pm[s]),
            .decision (dec[s])
        );
    end

    // When every survivor is in the upper half, dropping the MSB rebases all metrics by the same amount.
    always_comb begin
        for (int s = 0; s < NUM_STATES; s++)
            msb[s] = sel_pm[s][PM_W-1];
        norm = &msb;
        for (int s = 0; s < NUM_STATES; s++)
            new_pm[s] = norm ? {1'b0, sel_pm[s][PM_W-2:0]} : sel_pm[s];
    end

    // Linear minimum search; strict compare keeps the lowest index on ties.
    always_comb begin
        min_state  = '0;
        min_metric = new_pm[0];
        for (int s = 1; s < NUM_STATES; s++) begin
            if (new_pm[s] < min_metric) begin
                min_state  = 3'(s);
                min_metric = new_pm[s];
            end
        end
    end

    // Metric registers and output pipeline: update on valid steps, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_STATES; s++)
                pm[s] <= INIT_ZERO_MASK[s] ? '0 : INIT_PM;
            out_valid   <= 1'b0;
            decisions   <= '0;
            best_state  <= '0;
            best_metric <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                for (int s = 0; s < NUM_STATES; s++)
                    pm[s] <= new_pm[s];
                decisions   <= dec;
                best_state  <= min_state;
                best_metric <= min_metric;
            end
        end
    end

endmodule

// File: doc/path_metric_unit.md
Name: path_metric_unit

Overview:
- Add-compare-select (ACS) stage directly downstream of the per-state branch metric computation (BMC) blocks in the Viterbi decoder.
- Each valid symbol step, it consumes two 2-bit branch metrics per trellis state and updates 8 registered path metrics (rate 1/2, K=4).
- Emits one survivor decision bit per state, plus the best state and its metric, to the traceback stage.

Parameters:
- PM_W, 8, path metric width in bits; legal range 6..16.
- INIT_METRIC, 32, starting metric of states 1..7 at frame start; must be < 2^(PM_W-1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- frame_start  input  1  qualified by in_valid; this step starts a new frame.
- in_valid  input  1  bm0/bm1 hold a valid symbol step this cycle.
- bm0  input  16  8 x 2-bit; bm0[2s+1:2s] = metric of branch into state s from predecessor p0(s).
- bm1  input  16  8 x 2-bit; bm1[2s+1:2s] = metric of branch into state s from predecessor p1(s).
- out_valid  output  1  decisions/best_state/best_metric are valid.
- decisions  output  8  bit s = 1 when state s survivor came from p1(s).
- best_state  output  3  index of minimum updated path metric.
- best_metric  output  PM_W  value of that minimum metric.

Behaviour:
- Trellis: p0(s) = 2*(s mod 4), p1(s) = 2*(s mod 4)+1.
- Reset:
  - pm[0] = 0 and pm[1..7] = INIT_METRIC.
  - out_valid = 0, decisions = 0, best_state = 0, best_metric = 0.
- Old metric source for a step: the initial vector {0, INIT_METRIC x7} when frame_start & in_valid, else the pm registers.
- ACS per state s:
  - c0 = old[p0(s)] + bm0[s], c1 = old[p1(s)] + bm1[s]; sums computed in PM_W+1 bits, saturating at 2^PM_W-1.
  - Select c1 only if c1 < c0 (strict); ties pick c0 and decision 0.
- Normalization: if every selected metric has its MSB (bit PM_W-1) set, clear that MSB in all 8 metrics (equivalent to subtracting 2^(PM_W-1)) before registering.
- Best state: minimum over the post-normalization metrics; lowest index wins ties.
- Latency: one cycle. in_valid at edge N gives out_valid = 1 after edge N, with decisions/best_state/best_metric for that step; pm updated at the same edge.
- in_valid = 0:
  - pm, decisions, best_state and best_metric hold.
  - out_valid = 0 next cycle.
  - frame_start is ignored.
- Back-to-back in_valid: one step per cycle, no bubbles; there is no backpressure.
- rst asserted mid-frame: overrides in_valid; all state returns to reset values at that edge; the first step after reset need not carry frame_start.
- Saturation is defensive only: with bm ≤ 3 and normalization active, it never triggers.

Decomposition:
- Package vit_pkg holds:
  - NUM_STATES = 8, BM_W = 2.
  - Typedef bm_t (logic [1:0]).
  - Functions pred0(s) and pred1(s).
  - Shared constant for the initial metric vector layout.
- Sub-module acs_cell:
  - Inputs: two old metrics and two branch metrics.
  - Outputs: saturated selected metric and decision bit (combinational).
  - Instantiated 8 times.
- The parent owns the registers, normalization, min-finder and valid pipeline.

Test Plan:
- Reset check: hold rst 2 cycles -> out_valid=0, decisions=0, best_state=0, best_metric=0; internal pm = {0,32,32,32,32,32,32,32}.
- Frame start, all bm=0, in_valid=1, frame_start=1 -> next cycle out_valid=1, decisions=8'h00 (states 0,4: 0 vs 32; others tie 32=32), best_state=0, best_metric=0.
- Frame start with bm0=all 2'd3 and bm1=all 2'd0 -> states 0,4: c0=3, c1=32, decision 0; states 1,2,3,5,6,7: c1=32 < c0=35, decision 1; decisions=8'hEE, best_state=0, best_metric=3.
- Normalization: after frame start, drive bm0=bm1=all 2'd2 for 70 steps. At step k the surviving metrics are 2k (states 0,4) and 32+2k (others) until merging. On the first step where all 8 metrics ≥128, best_metric drops by exactly 128, decisions stay unchanged, and there is no saturation.
- Hold: deassert in_valid for 5 cycles mid-stream -> out_valid=0 each cycle; best_metric and decisions unchanged; resume with one step and verify it continues from the held pm.
- Mid-frame reset: pulse rst during back-to-back in_valid -> out_valid=0 the cycle after; next step without frame_start behaves exactly as the frame-start case above.
